// File: rtl/sevenseg_scan_ctrl_pkg.sv
// Shared widths, blanking constants and the leading-zero test for the
// multiplexed four-digit seven-segment scanner.
package sevenseg_scan_ctrl_pkg;

    localparam int NDIG  = 4;
    localparam int NIB_W = 4;
    localparam int SEG_W = 7;
    localparam int IDX_W = 2;
    localparam int VAL_W = NDIG * NIB_W;

    localparam logic [NDIG-1:0]  AN_OFF    = 4'b1111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // A digit is dark when blanking is on, it is not digit 0, and it and
    // every more significant nibble are zero.
    function automatic logic lead_zero_blank(
        input logic [VAL_W-1:0] disp,
        input logic [IDX_W-1:0] idx,
        input logic             en
    );
        logic upper_zero;
        upper_zero = 1'b1;
        for (int k = 0; k < NDIG; k++) begin
            if (k >= int'(idx) && disp[k*NIB_W +: NIB_W] != '0) begin
                upper_zero = 1'b0;
            end
        end
        return en && (idx != '0) && upper_zero;
    endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_rom.sv
// Hex-to-segment lookup, bit order {g,f,e,d,c,b,a}, active-high segments.
module sevenseg_rom
    import sevenseg_scan_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] addr,
    output logic [SEG_W-1:0] data
);

    always_comb begin
        data = SEG_BLANK;
        case (addr)
            4'h0: data = 7'h3F;
            4'h1: data = 7'h06;
            4'h2: data = 7'h5B;
            4'h3: data = 7'h4F;
            4'h4: data = 7'h66;
            4'h5: data = 7'h6D;
            4'h6: data = 7'h7D;
            4'h7: data = 7'h07;
            4'h8: data = 7'h7F;
            4'h9: data = 7'h6F;
            4'hA: data = 7'h77;
            4'hB: data = 7'h7C;
            4'hC: data = 7'h39;
            4'hD: data = 7'h5E;
            4'hE: data = 7'h79;
            4'hF: data = 7'h71;
            default: data = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Four-digit multiplexed display scanner with a one-deep pending buffer that
// only swaps into the display register at a frame boundary.
module sevenseg_scan_ctrl
    import sevenseg_scan_ctrl_pkg::*;
#(
    parameter int unsigned DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [VAL_W-1:0] value,
    input  logic             blank_lz,
    output logic             ready,
    output logic [NDIG-1:0]  an,
    output logic [SEG_W-1:0] seg
);

    localparam int unsigned     CNT_W   = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VAL_W-1:0] disp_q, disp_d;
    logic [VAL_W-1:0] pend_q, pend_d;
    logic             pending_q, pending_d;
    logic [NDIG-1:0]  an_q, an_d;
    logic [SEG_W-1:0] seg_q, seg_d;

    logic             tick;
    logic             blank;
    logic [NIB_W-1:0] rom_addr;
    logic [SEG_W-1:0] rom_data;

    assign rom_addr = disp_q[{idx_q, 2'b00} +: NIB_W];

    sevenseg_rom u_rom (
        .addr (rom_addr),
        .data (rom_data)
    );

    always_comb begin
        tick      = (cnt_q == CNT_MAX);
        cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d     = tick ? idx_q + IDX_W'(1) : idx_q;
        disp_d    = disp_q;
        pend_d    = pend_q;
        pending_d = pending_q;

        // Commit only at the last slot's tick so a frame never mixes values;
        // a load can never coincide with a commit because ready is low then.
        if (tick && idx_q == IDX_LAST && pending_q) begin
            disp_d    = pend_q;
            pending_d = 1'b0;
        end else if (load && !pending_q) begin
            pend_d    = value;
            pending_d = 1'b1;
        end

        blank = lead_zero_blank(disp_q, idx_q, blank_lz);
        an_d  = AN_OFF;
        if (!blank) begin
            an_d[idx_q] = 1'b0;
        end
        seg_d = blank ? SEG_BLANK : rom_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            disp_q    <= '0;
            pend_q    <= '0;
            pending_q <= 1'b0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_BLANK;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign ready = !pending_q;
    assign an    = an_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Self-checking bench: edge-count reference model compared every cycle, plus
// directed scenarios with literal segment/anode expectations.
module tb_sevenseg_scan_ctrl;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic        ready;
    logic [3:0]  an;
    logic [6:0]  seg;

    int n_checks = 0;
    int n_fail   = 0;

    int          m_edges;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_pending;
    bit          m_valid = 1'b0;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_ready;
    int          m_slot;

    sevenseg_scan_ctrl #(.DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .value    (value),
        .blank_lz (blank_lz),
        .ready    (ready),
        .an       (an),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic checkValue(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] ea, input logic [6:0] es);
        checkValue({name, "_an"}, 16'(an), 16'(ea));
        checkValue({name, "_seg"}, 16'(seg), 16'(es));
    endtask

    task automatic applyStimulus(input logic l, input logic [15:0] v, input logic b);
        load     = l;
        value    = v;
        blank_lz = b;
    endtask

    // One digit slot: sample right after the slot's first edge, then skip the rest.
    task automatic checkSlot(input string name, input logic [3:0] ea, input logic [6:0] es);
        @(negedge clk);
        checkOutput(name, ea, es);
        repeat (DIV - 1) @(negedge clk);
    endtask

    task automatic waitReady(input string name);
        int k;
        k = 0;
        while (ready !== 1'b1 && k < 4 * FRAME) begin
            @(negedge clk);
            k++;
        end
        checkValue({name, "_ready"}, 16'(ready), 16'h0001);
    endtask

    task automatic waitPhase(input int phase);
        int k;
        k = 0;
        while ((m_edges % FRAME) != phase && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        checkValue("phase_align", 16'(m_edges % FRAME), 16'(phase));
    endtask

    // Reference: everything follows from the number of edges since reset.
    always @(posedge clk) begin
        if (rst) begin
            m_edges   = 0;
            m_disp    = 16'h0000;
            m_pend    = 16'h0000;
            m_pending = 1'b0;
            exp_an    = 4'hF;
            exp_seg   = 7'h00;
            exp_ready = 1'b1;
            m_valid   = 1'b1;
        end else if (m_valid) begin
            m_slot = (m_edges / DIV) % 4;
            if (blank_lz && m_slot != 0 && (m_disp >> (4 * m_slot)) == 16'h0000) begin
                exp_an  = 4'hF;
                exp_seg = 7'h00;
            end else begin
                exp_an  = 4'hF ^ (4'b0001 << m_slot);
                exp_seg = hex_seg(4'(m_disp >> (4 * m_slot)));
            end
            if ((m_edges % FRAME) == FRAME - 1 && m_pending) begin
                m_disp    = m_pend;
                m_pending = 1'b0;
            end else if (load && !m_pending) begin
                m_pend    = value;
                m_pending = 1'b1;
            end
            exp_ready = !m_pending;
            m_edges++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checkValue("model_an", 16'(an), 16'(exp_an));
            checkValue("model_seg", 16'(seg), 16'(exp_seg));
            checkValue("model_ready", 16'(ready), 16'(exp_ready));
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] rv;
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset", 4'b1111, 7'h00);
        checkValue("reset_ready", 16'(ready), 16'h0001);
        rst = 1'b0;

        $display("[TB] idle scan");
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (i % DIV == 0) begin
                case ((i / DIV) % 4)
                    0: checkOutput("idle_d0", 4'b1110, 7'h3F);
                    1: checkOutput("idle_d1", 4'b1101, 7'h3F);
                    2: checkOutput("idle_d2", 4'b1011, 7'h3F);
                    default: checkOutput("idle_d3", 4'b0111, 7'h3F);
                endcase
            end
        end

        $display("[TB] load 1A3F, then ignored FFFF");
        applyStimulus(1'b1, 16'h1A3F, 1'b0);
        @(negedge clk);
        checkValue("load_ready_drop", 16'(ready), 16'h0000);
        applyStimulus(1'b1, 16'hFFFF, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        waitReady("commit_1a3f");
        for (int f = 0; f < 2; f++) begin
            checkSlot("show_1a3f_d0", 4'b1110, 7'h71);
            checkSlot("show_1a3f_d1", 4'b1101, 7'h4F);
            checkSlot("show_1a3f_d2", 4'b1011, 7'h77);
            checkSlot("show_1a3f_d3", 4'b0111, 7'h06);
        end

        $display("[TB] leading-zero blanking");
        applyStimulus(1'b1, 16'h0005, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        waitReady("commit_0005");
        checkSlot("blank5_d0", 4'b1110, 7'h6D);
        checkSlot("blank5_d1", 4'b1111, 7'h00);
        checkSlot("blank5_d2", 4'b1111, 7'h00);
        checkSlot("blank5_d3", 4'b1111, 7'h00);
        applyStimulus(1'b1, 16'h0000, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        waitReady("commit_0000");
        checkSlot("blank0_d0", 4'b1110, 7'h3F);
        checkSlot("blank0_d1", 4'b1111, 7'h00);
        checkSlot("blank0_d2", 4'b1111, 7'h00);
        checkSlot("blank0_d3", 4'b1111, 7'h00);

        $display("[TB] load coincident with frame-wrap tick");
        applyStimulus(1'b0, 16'h0000, 1'b0);
        waitPhase(FRAME - 1);
        applyStimulus(1'b1, 16'h00C7, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        checkValue("coinc_ready", 16'(ready), 16'h0000);
        checkSlot("coinc_old_d0", 4'b1110, 7'h3F);
        checkSlot("coinc_old_d1", 4'b1101, 7'h3F);
        checkSlot("coinc_old_d2", 4'b1011, 7'h3F);
        checkSlot("coinc_old_d3", 4'b0111, 7'h3F);
        checkValue("coinc_ready_after", 16'(ready), 16'h0001);
        checkSlot("coinc_new_d0", 4'b1110, 7'h07);
        checkSlot("coinc_new_d1", 4'b1101, 7'h39);
        checkSlot("coinc_new_d2", 4'b1011, 7'h3F);
        checkSlot("coinc_new_d3", 4'b0111, 7'h3F);

        $display("[TB] reset with pending value");
        applyStimulus(1'b1, 16'hBEEF, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        checkValue("rstpend_ready", 16'(ready), 16'h0000);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstpend_reset", 4'b1111, 7'h00);
        checkValue("rstpend_reset_ready", 16'(ready), 16'h0001);
        rst = 1'b0;
        for (int f = 0; f < 2; f++) begin
            checkSlot("after_rst_d0", 4'b1110, 7'h3F);
            checkSlot("after_rst_d1", 4'b1101, 7'h3F);
            checkSlot("after_rst_d2", 4'b1011, 7'h3F);
            checkSlot("after_rst_d3", 4'b0111, 7'h3F);
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rv = 16'h0000;
            for (int d = 0; d < 4; d++) begin
                if ($urandom_range(0, 1) == 1) rv[d*4 +: 4] = 4'($urandom_range(0, 15));
            end
            rst = ($urandom_range(0, 299) == 0);
            applyStimulus($urandom_range(0, 5) == 0, rv,
                          ($urandom_range(0, 49) == 0) ? ~blank_lz : blank_lz);
        end
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0);
        repeat (2 * FRAME) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
